ctu_tsr_ctl: RTL and testbench
==============================

Name: ctu_tsr_ctl

Overview:
Sequencer for the on-die temperature sensor in the CTU pad cluster, whose analog test signals leave through the tsr_testio pads.
- Powers the sensor and waits for analog settle.
- Drives a single-slope ramp DAC code and samples the sensor comparator.
- Captures the trip code as the temperature result.
- Conversions are triggered one-shot by CSR or by a programmable periodic timer; results go to CSR space with a valid pulse and a sticky overflow flag.

Parameters:
- CNT_W, 8, DAC code and result width; full-scale code = 2^CNT_W-1.
- SETTLE_CYC, 64, cycles tsr_pwr_en is held before the ramp starts (>=1).
- STEP_CYC, 4, cycles each DAC code is held; must be >=3 to cover comparator sync latency.
- PERIOD_W, 16, width of the periodic interval field.

Ports:
- jbus_clk  input  1  block clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- csr_start  input  1  one-cycle pulse: request one conversion.
- csr_en  input  1  enable periodic conversions.
- csr_period  input  PERIOD_W  periodic interval in cycles; 0 = no periodic triggers.
- csr_ovf_clr  input  1  pulse: clear tsr_ovf.
- tsr_cmp  input  1  sensor comparator output; asynchronous; 1 = reference above sensor voltage.
- tsr_pwr_en  output  1  sensor analog power/enable.
- tsr_dac  output  CNT_W  ramp reference code to the sensor DAC.
- tsr_busy  output  1  conversion in progress; high when state is not IDLE.
- tsr_data  output  CNT_W  last conversion result; holds between conversions.
- tsr_vld  output  1  one-cycle pulse when tsr_data updates.
- tsr_ovf  output  1  sticky: ramp reached full scale without a trip.

Behaviour:
Reset:
- rst is asynchronous, active-high.
- While asserted, all outputs are 0, the FSM is IDLE, and the timer, pending flag and synchroniser are cleared.
- Reset mid-conversion aborts immediately; no tsr_vld is produced.

Comparator path:
- tsr_cmp passes through a 2-flop synchroniser to give cmp_s.
- The FSM uses only cmp_s.

Periodic timer:
- Held at 0 when csr_en=0 or csr_period=0.
- Otherwise increments each cycle. At value csr_period-1 it emits a one-cycle tick and wraps to 0.
- Runs in every FSM state.
- A change to csr_period takes effect on the next compare. If the count is already above the new value, the count wraps naturally through full scale.

Trigger:
- trig = csr_start | tick.
- pending is a 1-bit flag. It is set when trig occurs while state is not IDLE, and cleared on entry to SETTLE.
- Multiple triggers while busy collapse into one pending conversion.

FSM:
- IDLE:
  - tsr_pwr_en=0, tsr_dac=0.
  - On trig or pending, go to SETTLE. Settle counter and dac are set to 0 and pending is cleared.
  - Trig together with pending yields one conversion.
- SETTLE:
  - tsr_pwr_en=1, tsr_dac=0.
  - Stays SETTLE_CYC cycles, then goes to RAMP with the step counter at 0.
- RAMP:
  - tsr_pwr_en=1.
  - Each code is held STEP_CYC cycles. cmp_s is evaluated on the last hold cycle:
    - cmp_s=1: result=tsr_dac, go to DONE.
    - cmp_s=0 and tsr_dac=full scale: result=full scale, set tsr_ovf, go to DONE.
    - Otherwise: tsr_dac+1 and restart the hold.
- DONE (one cycle):
  - tsr_vld=1; tsr_data shows the result in this same cycle.
  - tsr_pwr_en=1 and tsr_dac holds its last code.
  - Next state is IDLE; tsr_pwr_en and tsr_dac are 0 from the IDLE cycle onward.
- csr_en deasserting mid-conversion does not abort; the conversion completes.

Latency:
- Trigger sampled at edge t, trip at code k.
- tsr_vld is high in cycle t+1+SETTLE_CYC+(k+1)*STEP_CYC.
- Back-to-back (pending) conversions insert exactly one IDLE cycle.

tsr_ovf:
- Set on a full-scale no-trip result.
- Cleared by csr_ovf_clr. If set and clear happen in the same cycle, set wins.
- A successful conversion does not clear it.

Test Plan:
1. Reset: assert rst mid-clock with no clock edge -> all outputs 0 immediately; after release, tsr_busy=0 and tsr_dac=0.
2. Single shot: defaults, bench drives tsr_cmp=1 when tsr_dac>=37; csr_start at edge t -> tsr_vld in cycle t+217, tsr_data=37, tsr_ovf=0, tsr_pwr_en=0 the next cycle.
3. No trip: tsr_cmp=0 always, csr_start -> tsr_data=255, tsr_ovf=1 with tsr_vld. Then csr_ovf_clr -> tsr_ovf=0. Repeat with csr_ovf_clr coincident with the set -> tsr_ovf=1.
4. Periodic: csr_en=1, csr_period=2000, trip at code 10 -> tsr_vld every 2000 cycles. Deassert csr_en mid-RAMP -> current result delivered, no further tsr_vld.
5. Pending: three csr_start pulses during RAMP -> exactly one extra conversion, starting one IDLE cycle after DONE; total two tsr_vld pulses.
6. Abort: rst pulse during RAMP at code 20 -> no tsr_vld, tsr_data=0. csr_start after release -> normal conversion with correct latency. Also check a tsr_cmp glitch shorter than one cycle outside the sample point does not alter the result.

Source files
------------

// File: rtl/ctu_tsr_ctl.sv
// Temperature-sensor sequencer: powers the sensor, waits for it to settle, steps a single-slope
// DAC ramp and captures the first code at which the synchronised comparator trips.
module ctu_tsr_ctl #(
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 64,
  parameter int STEP_CYC   = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                jbus_clk,
  input  logic                rst,
  input  logic                csr_start,
  input  logic                csr_en,
  input  logic [PERIOD_W-1:0] csr_period,
  input  logic                csr_ovf_clr,
  input  logic                tsr_cmp,
  output logic                tsr_pwr_en,
  output logic [CNT_W-1:0]    tsr_dac,
  output logic                tsr_busy,
  output logic [CNT_W-1:0]    tsr_data,
  output logic                tsr_vld,
  output logic                tsr_ovf
);

  localparam int WAIT_MAX = (SETTLE_CYC > STEP_CYC) ? SETTLE_CYC : STEP_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [WAIT_W-1:0]   SETTLE_LAST = WAIT_W'(SETTLE_CYC - 1);
  localparam logic [WAIT_W-1:0]   STEP_LAST   = WAIT_W'(STEP_CYC - 1);
  localparam logic [WAIT_W-1:0]   WAIT_ONE    = WAIT_W'(1);
  localparam logic [CNT_W-1:0]    DAC_FULL    = '1;
  localparam logic [CNT_W-1:0]    DAC_ONE     = CNT_W'(1);
  localparam logic [PERIOD_W-1:0] PER_ONE     = PERIOD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RAMP,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    dac_q, dac_d;
  logic [CNT_W-1:0]    data_q, data_d;
  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  logic                pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                cmp_meta_q, cmp_s_q;
  logic                tick;
  logic                trig;
  logic                ovf_set;

  always_ff @(posedge jbus_clk or posedge rst) begin
    if (rst) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= tsr_cmp;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  // The count may sit above a freshly lowered period; it then wraps through full scale.
  always_comb begin
    tick  = 1'b0;
    tmr_d = '0;
    if (csr_en && (csr_period != '0)) begin
      if (tmr_q == (csr_period - PER_ONE)) begin
        tick = 1'b1;
      end else begin
        tmr_d = tmr_q + PER_ONE;
      end
    end
  end

  assign trig = csr_start | tick;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    dac_d   = dac_q;
    data_d  = data_q;
    pend_d  = pend_q;
    ovf_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig || pend_q) begin
          state_d = ST_SETTLE;
          wait_d  = '0;
          dac_d   = '0;
          pend_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (wait_q == SETTLE_LAST) begin
          state_d = ST_RAMP;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      ST_RAMP: begin
        if (wait_q == STEP_LAST) begin
          wait_d = '0;
          if (cmp_s_q) begin
            data_d  = dac_q;
            state_d = ST_DONE;
          end else if (dac_q == DAC_FULL) begin
            data_d  = DAC_FULL;
            ovf_set = 1'b1;
            state_d = ST_DONE;
          end else begin
            dac_d = dac_q + DAC_ONE;
          end
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        dac_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        dac_d   = '0;
      end
    endcase
    // Any number of triggers while busy collapse into a single follow-up conversion.
    if ((state_q != ST_IDLE) && trig) begin
      pend_d = 1'b1;
    end
  end

  assign ovf_d = ovf_set | (ovf_q & ~csr_ovf_clr);

  always_ff @(posedge jbus_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      dac_q   <= '0;
      data_q  <= '0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      dac_q   <= dac_d;
      data_q  <= data_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tsr_busy   = (state_q != ST_IDLE);
  assign tsr_pwr_en = (state_q != ST_IDLE);
  assign tsr_vld    = (state_q == ST_DONE);
  assign tsr_dac    = dac_q;
  assign tsr_data   = data_q;
  assign tsr_ovf    = ovf_q;

endmodule

// File: tb/tb_ctu_tsr_ctl.sv
// Bench for ctu_tsr_ctl: directed scenarios plus randomized traffic, checked every cycle against
// an event-level model that predicts each conversion's start, trip code and completion cycle.
module tb_ctu_tsr_ctl;

  localparam int CNT_W      = 8;
  localparam int SETTLE_CYC = 64;
  localparam int STEP_CYC   = 4;
  localparam int PERIOD_W   = 16;
  localparam int FS         = (1 << CNT_W) - 1;

  logic                jbus_clk = 1'b0;
  logic                rst = 1'b0;
  logic                csr_start = 1'b0;
  logic                csr_en = 1'b0;
  logic [PERIOD_W-1:0] csr_period = '0;
  logic                csr_ovf_clr = 1'b0;
  logic                tsr_cmp = 1'b0;
  logic                tsr_pwr_en;
  logic [CNT_W-1:0]    tsr_dac;
  logic                tsr_busy;
  logic [CNT_W-1:0]    tsr_data;
  logic                tsr_vld;
  logic                tsr_ovf;

  ctu_tsr_ctl #(
    .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .STEP_CYC(STEP_CYC), .PERIOD_W(PERIOD_W)
  ) dut (
    .jbus_clk(jbus_clk), .rst(rst), .csr_start(csr_start), .csr_en(csr_en),
    .csr_period(csr_period), .csr_ovf_clr(csr_ovf_clr), .tsr_cmp(tsr_cmp),
    .tsr_pwr_en(tsr_pwr_en), .tsr_dac(tsr_dac), .tsr_busy(tsr_busy),
    .tsr_data(tsr_data), .tsr_vld(tsr_vld), .tsr_ovf(tsr_ovf)
  );

  always #5 jbus_clk = ~jbus_clk;

  int vectors = 0;
  int miscompares = 0;

  // Sensor trips whenever the DAC code is at or above thr; thr > FS never trips.
  int thr = 1000;
  bit glitch = 1'b0;

  // Reference model: one conversion described by start edge, completion edge and trip code.
  int n_edge = 0;
  bit m_act = 1'b0;
  int m_s = 0, m_v = 0, m_k = 0;
  bit m_novf = 1'b0;
  bit m_pend = 1'b0;
  bit m_ovf = 1'b0;
  int m_data = 0;
  int m_tmr = 0;

  int vld_seen = 0;
  int last_vld_edge = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, n_edge);
    end
  endtask

  task automatic model_reset();
    m_act  = 1'b0;
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    m_data = 0;
    m_tmr  = 0;
  endtask

  task automatic model_edge();
    bit tick, trig, idle_before;
    n_edge++;
    if (rst) begin
      model_reset();
      return;
    end
    tick = 1'b0;
    if (!csr_en || csr_period == '0) begin
      m_tmr = 0;
    end else if (m_tmr == int'(csr_period) - 1) begin
      tick  = 1'b1;
      m_tmr = 0;
    end else begin
      m_tmr = (m_tmr + 1) % 65536;
    end
    trig = csr_start | tick;
    idle_before = !(m_act && n_edge >= m_s + 1 && n_edge <= m_v + 1);
    if (m_act && n_edge == m_v) m_data = m_k;
    if (m_act && n_edge == m_v && m_novf) m_ovf = 1'b1;
    else if (csr_ovf_clr) m_ovf = 1'b0;
    if (idle_before) begin
      if (trig || m_pend) begin
        m_act  = 1'b1;
        m_s    = n_edge;
        m_pend = 1'b0;
        if (thr <= FS) begin
          m_k = thr;
          m_novf = 1'b0;
        end else begin
          m_k = FS;
          m_novf = 1'b1;
        end
        m_v = m_s + SETTLE_CYC + (m_k + 1) * STEP_CYC;
      end
    end else if (trig) begin
      m_pend = 1'b1;
    end
  endtask

  function automatic logic [19:0] outs();
    return {tsr_busy, tsr_pwr_en, tsr_vld, tsr_ovf, tsr_dac, tsr_data};
  endfunction

  task automatic check_cycle();
    bit e_busy, e_vld;
    int e_dac;
    logic [19:0] exp_v;
    e_busy = m_act && n_edge >= m_s && n_edge <= m_v;
    e_vld  = m_act && n_edge == m_v;
    e_dac  = 0;
    if (m_act && n_edge >= m_s + SETTLE_CYC && n_edge < m_v)
      e_dac = (n_edge - m_s - SETTLE_CYC) / STEP_CYC;
    else if (e_vld)
      e_dac = m_k;
    exp_v = {e_busy, e_busy, e_vld, m_ovf, e_dac[7:0], m_data[7:0]};
    chk("busy_pwr_vld_ovf_dac_data", 32'(outs()), 32'(exp_v));
  endtask

  // One clock: model at the edge, optional sub-cycle comparator glitch, check at the falling edge.
  task automatic step();
    @(posedge jbus_clk);
    model_edge();
    if (glitch) begin
      #1 tsr_cmp = ~tsr_cmp;
      #2 tsr_cmp = ~tsr_cmp;
    end
    @(negedge jbus_clk);
    check_cycle();
    if (tsr_vld === 1'b1) begin
      vld_seen++;
      last_vld_edge = n_edge;
    end
    tsr_cmp = (int'(tsr_dac) >= thr);
  endtask

  task automatic run_until_vld(input string tag, input int budget);
    int base;
    bit ok;
    base = vld_seen;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (vld_seen != base) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic run_until_dac(input string tag, input int code, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (int'(tsr_dac) == code) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    csr_start = 1'b1;
    step();
    csr_start = 1'b0;
  endtask

  // Called at a falling edge: reset goes high between clock edges and is checked before any edge.
  task automatic apply_reset(input int cycles);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_outs", 32'(outs()), 32'd0);
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!((m_act && n_edge <= m_v + 1) || m_pend)) break;
      step();
    end
    chk("drain_idle", 32'(tsr_busy), 32'd0);
  endtask

  initial begin
    int start_edge, v1, base;

    // Reset asserted between edges.
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_init_outs", 32'(outs()), 32'd0);
    @(negedge jbus_clk);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(tsr_busy), 32'd0);
    chk("post_rst_dac", 32'(tsr_dac), 32'd0);

    // Single shot, trip at 37.
    thr = 37;
    pulse_start();
    start_edge = n_edge;
    run_until_vld("single_vld", 2000);
    chk("single_latency", 32'(last_vld_edge - start_edge), 32'(SETTLE_CYC + 38 * STEP_CYC));
    chk("single_data", 32'(tsr_data), 32'd37);
    chk("single_ovf", 32'(tsr_ovf), 32'd0);
    step();
    chk("single_pwr_off", 32'(tsr_pwr_en), 32'd0);

    // No trip: full-scale result with overflow, then clear.
    thr = 1000;
    pulse_start();
    run_until_vld("ovf_vld", 2000);
    chk("ovf_data", 32'(tsr_data), 32'(FS));
    chk("ovf_set", 32'(tsr_ovf), 32'd1);
    csr_ovf_clr = 1'b1;
    step();
    csr_ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(tsr_ovf), 32'd0);

    // Clear coincident with set: set wins.
    pulse_start();
    for (int i = 0; i < 2000 && (m_v - n_edge) > 1; i++) step();
    csr_ovf_clr = 1'b1;
    step();
    csr_ovf_clr = 1'b0;
    chk("ovf_coinc_vld", 32'(tsr_vld), 32'd1);
    chk("ovf_coinc_set", 32'(tsr_ovf), 32'd1);
    csr_ovf_clr = 1'b1;
    step();
    csr_ovf_clr = 1'b0;

    // Periodic conversions every 2000 cycles, trip at 10.
    thr = 10;
    csr_period = 16'd2000;
    csr_en = 1'b1;
    run_until_vld("per_vld1", 2500);
    v1 = last_vld_edge;
    chk("per_data", 32'(tsr_data), 32'd10);
    run_until_vld("per_vld2", 2500);
    chk("per_interval", 32'(last_vld_edge - v1), 32'd2000);
    run_until_dac("per_ramp5", 5, 2500);
    csr_en = 1'b0;
    run_until_vld("per_finish", 200);
    base = vld_seen;
    repeat (4500) step();
    chk("per_stopped", 32'(vld_seen - base), 32'd0);
    csr_period = '0;

    // Three starts during RAMP collapse into one extra conversion after a single IDLE cycle.
    thr = 50;
    base = vld_seen;
    pulse_start();
    run_until_dac("pend_ramp", 3, 500);
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      repeat (5) step();
    end
    run_until_vld("pend_vld1", 2000);
    step();
    chk("pend_gap_idle", 32'(tsr_busy), 32'd0);
    step();
    chk("pend_restart", 32'(tsr_busy), 32'd1);
    run_until_vld("pend_vld2", 2000);
    repeat (1500) step();
    chk("pend_count", 32'(vld_seen - base), 32'd2);

    // Abort mid-ramp, then a clean conversion with comparator glitches every cycle.
    thr = 100;
    pulse_start();
    run_until_dac("abort_ramp", 20, 500);
    base = vld_seen;
    apply_reset(2);
    chk("abort_data", 32'(tsr_data), 32'd0);
    repeat (300) step();
    chk("abort_no_vld", 32'(vld_seen - base), 32'd0);
    thr = 20;
    step();
    pulse_start();
    start_edge = n_edge;
    glitch = 1'b1;
    run_until_vld("glitch_vld", 2000);
    glitch = 1'b0;
    chk("glitch_latency", 32'(last_vld_edge - start_edge), 32'(SETTLE_CYC + 21 * STEP_CYC));
    chk("glitch_data", 32'(tsr_data), 32'd20);

    // Randomized traffic.
    for (int ph = 0; ph < 6; ph++) begin
      csr_en = 1'b0;
      csr_start = 1'b0;
      drain(3000);
      thr = $urandom_range(0, 300);
      csr_en = 1'($urandom_range(0, 1));
      csr_period = PERIOD_W'($urandom_range(100, 700));
      for (int i = 0; i < 2500; i++) begin
        csr_start = ($urandom_range(0, 199) == 0);
        csr_ovf_clr = ($urandom_range(0, 99) == 0);
        glitch = ($urandom_range(0, 9) == 0);
        step();
      end
      csr_start = 1'b0;
      csr_ovf_clr = 1'b0;
      glitch = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1);
  end

endmodule
